// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the front-end redirect sequencer: PC width and FSM encodings.
package branch_redirect_ctrl_pkg;

  localparam int PC_WIDTH = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_SQUASH = 2'd2;

endpackage

// File: rtl/branch_redirect_ctrl.sv
// Redirect sequencer: arbitrates execute/decode branch redirects oldest-first, holds the
// target to fetch until accepted, flushes wrong-path stages and squashes decode redirects.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int SQUASH_CYCLES = 2,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_br0_valid,
  input  logic                   i_br0_taken,
  input  logic [PC_WIDTH-1:0]    i_br0_pc,
  input  logic                   i_br1_valid,
  input  logic                   i_br1_taken,
  input  logic [PC_WIDTH-1:0]    i_br1_pc,
  input  logic                   i_ex_change_pc,
  input  logic [PC_WIDTH-1:0]    i_ex_pc,
  input  logic                   i_if_ready,
  output logic                   o_redirect_valid,
  output logic [PC_WIDTH-1:0]    o_redirect_pc,
  output logic                   o_flush_if,
  output logic                   o_flush_id,
  output logic                   o_kill_lane1,
  output logic                   o_busy,
  output logic [COUNT_WIDTH-1:0] o_redirect_count
);

  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);

  logic                   ex_req;
  logic                   d0_req;
  logic                   d1_req;
  logic [1:0]             state_p1;
  logic [PC_WIDTH-1:0]    redirect_pc_p1;
  logic                   flush_if_p1;
  logic                   flush_id_p1;
  logic [COUNT_WIDTH-1:0] count_p1;
  logic [3:0]             sq_cnt_p1;

  // Oldest instruction wins: execute stage, then lane 0, then lane 1.
  function automatic logic [PC_WIDTH-1:0] pick_target(
    input logic                ex,
    input logic                d0,
    input logic [PC_WIDTH-1:0] ex_pc,
    input logic [PC_WIDTH-1:0] d0_pc,
    input logic [PC_WIDTH-1:0] d1_pc
  );
    if (ex)      return ex_pc;
    else if (d0) return d0_pc;
    else         return d1_pc;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (&c) ? c : c + COUNT_WIDTH'(1);
  endfunction

  assign ex_req = i_ex_change_pc;
  assign d0_req = i_br0_valid & i_br0_taken;
  assign d1_req = i_br1_valid & i_br1_taken;

  // Decode stage -> redirect register (visible one cycle after sampling)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_p1       <= ST_IDLE;
      redirect_pc_p1 <= '0;
      flush_if_p1    <= 1'b0;
      flush_id_p1    <= 1'b0;
      count_p1       <= '0;
      sq_cnt_p1      <= '0;
    end else begin
      flush_if_p1 <= 1'b0;
      flush_id_p1 <= 1'b0;
      case (state_p1)
        ST_IDLE: begin
          if (ex_req | d0_req | d1_req) begin
            redirect_pc_p1 <= pick_target(ex_req, d0_req, i_ex_pc, i_br0_pc, i_br1_pc);
            flush_if_p1    <= 1'b1;
            flush_id_p1    <= ex_req;
            state_p1       <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A fresh execute redirect supersedes the pending one, even on an accept edge.
          if (ex_req) begin
            redirect_pc_p1 <= i_ex_pc;
            flush_if_p1    <= 1'b1;
            flush_id_p1    <= 1'b1;
          end else if (i_if_ready) begin
            count_p1  <= sat_inc(count_p1);
            sq_cnt_p1 <= SQ_LOAD;
            state_p1  <= ST_SQUASH;
          end
        end
        ST_SQUASH: begin
          if (ex_req) begin
            redirect_pc_p1 <= i_ex_pc;
            flush_if_p1    <= 1'b1;
            flush_id_p1    <= 1'b1;
            sq_cnt_p1      <= '0;
            state_p1       <= ST_REQ;
          end else begin
            sq_cnt_p1 <= sq_cnt_p1 - 4'd1;
            if (sq_cnt_p1 <= 4'd1) state_p1 <= ST_IDLE;
          end
        end
        default: state_p1 <= ST_IDLE;
      endcase
    end
  end

  assign o_redirect_valid = (state_p1 == ST_REQ);
  assign o_redirect_pc    = redirect_pc_p1;
  assign o_flush_if       = flush_if_p1;
  assign o_flush_id       = flush_id_p1;
  assign o_busy           = (state_p1 != ST_IDLE);
  assign o_redirect_count = count_p1;
  assign o_kill_lane1     = d0_req & ~ex_req & (state_p1 == ST_IDLE);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; a second narrow-counter instance shares the
// stimulus so counter saturation is reached in a handful of redirects.
module tb_branch_redirect_ctrl;
  import branch_redirect_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                br0_valid, br0_taken, br1_valid, br1_taken;
  logic [PC_WIDTH-1:0] br0_pc, br1_pc, ex_pc;
  logic                ex_change_pc, if_ready;

  logic                redirect_valid, flush_if, flush_id, kill_lane1, busy;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [15:0]         redirect_count;

  logic                s_valid, s_flush_if, s_flush_id, s_kill, s_busy;
  logic [PC_WIDTH-1:0] s_pc;
  logic [1:0]          s_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.SQUASH_CYCLES(2), .COUNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_br0_valid(br0_valid), .i_br0_taken(br0_taken), .i_br0_pc(br0_pc),
    .i_br1_valid(br1_valid), .i_br1_taken(br1_taken), .i_br1_pc(br1_pc),
    .i_ex_change_pc(ex_change_pc), .i_ex_pc(ex_pc), .i_if_ready(if_ready),
    .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .o_flush_if(flush_if), .o_flush_id(flush_id), .o_kill_lane1(kill_lane1),
    .o_busy(busy), .o_redirect_count(redirect_count)
  );

  branch_redirect_ctrl #(.SQUASH_CYCLES(2), .COUNT_WIDTH(2)) dut_sat (
    .i_clk(clk), .i_rst(rst),
    .i_br0_valid(br0_valid), .i_br0_taken(br0_taken), .i_br0_pc(br0_pc),
    .i_br1_valid(br1_valid), .i_br1_taken(br1_taken), .i_br1_pc(br1_pc),
    .i_ex_change_pc(ex_change_pc), .i_ex_pc(ex_pc), .i_if_ready(if_ready),
    .o_redirect_valid(s_valid), .o_redirect_pc(s_pc),
    .o_flush_if(s_flush_if), .o_flush_id(s_flush_id), .o_kill_lane1(s_kill),
    .o_busy(s_busy), .o_redirect_count(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    br0_valid = 0; br0_taken = 0; br0_pc = '0;
    br1_valid = 0; br1_taken = 0; br1_pc = '0;
    ex_change_pc = 0; ex_pc = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_req();
    if_ready = 0;
    tick(); tick();
    chk("rst_valid", 32'(redirect_valid), 32'h0);
    chk("rst_pc",    redirect_pc,         32'h0);
    chk("rst_busy",  32'(busy),           32'h0);
    chk("rst_count", 32'(redirect_count), 32'h0);
    chk("rst_flush", 32'({flush_if, flush_id}), 32'h0);
    rst = 1'b0;
    tick();

    // Lane 1 alone with fetch ready
    br1_valid = 1; br1_taken = 1; br1_pc = 32'h40; if_ready = 1;
    #1 chk("l1_kill", 32'(kill_lane1), 32'h0);
    tick();
    clear_req();
    chk("l1_valid",   32'(redirect_valid), 32'h1);
    chk("l1_pc",      redirect_pc,         32'h40);
    chk("l1_flushif", 32'(flush_if),       32'h1);
    chk("l1_flushid", 32'(flush_id),       32'h0);
    chk("l1_busy",    32'(busy),           32'h1);
    chk("l1_cnt0",    32'(redirect_count), 32'h0);
    tick();
    chk("l1_drop",    32'(redirect_valid), 32'h0);
    chk("l1_cnt1",    32'(redirect_count), 32'h1);
    chk("l1_pulse",   32'(flush_if),       32'h0);
    tick(); tick();
    chk("l1_idle",    32'(busy),           32'h0);

    // Both lanes taken, fetch stalled; EX overrides mid-hold
    if_ready = 0;
    br0_valid = 1; br0_taken = 1; br0_pc = 32'h100;
    br1_valid = 1; br1_taken = 1; br1_pc = 32'h200;
    #1 chk("both_kill", 32'(kill_lane1), 32'h1);
    tick();
    clear_req();
    chk("both_pc",    redirect_pc,         32'h100);
    chk("both_valid", 32'(redirect_valid), 32'h1);
    chk("both_fid",   32'(flush_id),       32'h0);
    tick();
    chk("hold_pc",    redirect_pc,         32'h100);
    chk("hold_valid", 32'(redirect_valid), 32'h1);
    chk("hold_fif",   32'(flush_if),       32'h0);
    ex_change_pc = 1; ex_pc = 32'h300;
    br0_valid = 1; br0_taken = 1; br0_pc = 32'h500;
    #1 chk("req_kill", 32'(kill_lane1), 32'h0);
    tick();
    clear_req();
    chk("ex_pc",    redirect_pc,         32'h300);
    chk("ex_fid",   32'(flush_id),       32'h1);
    chk("ex_fif",   32'(flush_if),       32'h1);
    chk("ex_valid", 32'(redirect_valid), 32'h1);
    tick();
    chk("ex_fid_pulse", 32'(flush_id),       32'h0);
    chk("ex_cnt1",      32'(redirect_count), 32'h1);
    if_ready = 1;
    tick();
    chk("ex_cnt2",   32'(redirect_count), 32'h2);
    chk("ex_drop",   32'(redirect_valid), 32'h0);
    chk("sat_cnt2",  32'(s_count),        32'h2);

    // Squash window: D0 ignored for two cycles, accepted on the third
    br0_valid = 1; br0_taken = 1; br0_pc = 32'h600;
    #1 chk("sq1_kill", 32'(kill_lane1), 32'h0);
    tick();
    chk("sq2_valid", 32'(redirect_valid), 32'h0);
    chk("sq2_busy",  32'(busy),           32'h1);
    tick();
    chk("sq3_busy",  32'(busy),           32'h0);
    chk("sq3_kill",  32'(kill_lane1),     32'h1);
    tick();
    clear_req();
    chk("sq_valid",  32'(redirect_valid), 32'h1);
    chk("sq_pc",     redirect_pc,         32'h600);
    tick();
    chk("sq_cnt3",   32'(redirect_count), 32'h3);
    chk("sat_cnt3",  32'(s_count),        32'h3);

    // EX in SQUASH returns to REQ; EX together with ready discards old pc uncounted
    ex_change_pc = 1; ex_pc = 32'h700;
    tick();
    chk("sqex_pc",    redirect_pc,         32'h700);
    chk("sqex_fid",   32'(flush_id),       32'h1);
    chk("sqex_valid", 32'(redirect_valid), 32'h1);
    ex_pc = 32'h800;
    tick();
    clear_req();
    chk("exrdy_pc",    redirect_pc,         32'h800);
    chk("exrdy_valid", 32'(redirect_valid), 32'h1);
    chk("exrdy_cnt",   32'(redirect_count), 32'h3);
    tick();
    chk("exrdy_cnt4",  32'(redirect_count), 32'h4);
    chk("sat_hold",    32'(s_count),        32'h3);
    tick(); tick();
    chk("idle2", 32'(busy), 32'h0);

    // EX beats D0 from IDLE
    if_ready = 0;
    ex_change_pc = 1; ex_pc = 32'h900;
    br0_valid = 1; br0_taken = 1; br0_pc = 32'hA00;
    #1 chk("prio_kill", 32'(kill_lane1), 32'h0);
    tick();
    clear_req();
    chk("prio_pc",  redirect_pc,   32'h900);
    chk("prio_fid", 32'(flush_id), 32'h1);

    // Asynchronous reset while a redirect is pending
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(redirect_valid), 32'h0);
    chk("arst_pc",    redirect_pc,         32'h0);
    chk("arst_busy",  32'(busy),           32'h0);
    chk("arst_count", 32'(redirect_count), 32'h0);
    chk("arst_flush", 32'({flush_if, flush_id}), 32'h0);
    chk("arst_sat",   32'(s_count),        32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
